// File: rtl/reg_sch.sv
// Parallel-load register with load enable and asynchronous active-high clear.
// Optional feature macro REG_SCH_PARITY_EN adds a registered parity output with error injection.
module reg_sch #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [63:0] RESET_VALUE = 64'h0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] REG_IN,
`ifdef REG_SCH_PARITY_EN
  input  logic             PAR_ERR_INJ,
  output logic             REG_PAR,
`endif
  output logic [WIDTH-1:0] REG_OUT
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] data_nxt;

  // Mux rather than an if-hold so that an unknown LOAD propagates X instead of holding.
  always_comb begin
    data_nxt = LOAD ? REG_IN : REG_OUT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REG_OUT <= RST_VAL;
    end else begin
      REG_OUT <= data_nxt;
    end
  end

`ifdef REG_SCH_PARITY_EN
  localparam logic PAR_RST = ^RST_VAL;

  logic par_nxt;

  // Parity is computed from the incoming word so it lands on the same edge as the data.
  always_comb begin
    par_nxt = LOAD ? ((^REG_IN) ^ PAR_ERR_INJ) : REG_PAR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REG_PAR <= PAR_RST;
    end else begin
      REG_PAR <= par_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_reg_sch.sv
// Self-checking bench for reg_sch: directed vector table, randomized run against a
// behavioural model, plus WIDTH=16/RESET_VALUE and optional parity sequences.
`timescale 1ns/1ps
module tb_reg_sch;

  localparam logic [7:0]  RV8  = 8'h00;
  localparam logic [15:0] RV16 = 16'hA5A5;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  din8;
  logic [7:0]  dout8;
  logic [15:0] din16;
  logic [15:0] dout16;
`ifdef REG_SCH_PARITY_EN
  logic        inj;
  logic        par8;
  logic        inj16;
  logic        par16;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  m8;
  logic [15:0] m16;
  logic        mpar;

  reg_sch #(.WIDTH(8), .RESET_VALUE(64'h0)) dut8 (
    .CLK(clk), .RST(rst), .LOAD(load), .REG_IN(din8),
`ifdef REG_SCH_PARITY_EN
    .PAR_ERR_INJ(inj), .REG_PAR(par8),
`endif
    .REG_OUT(dout8)
  );

  reg_sch #(.WIDTH(16), .RESET_VALUE(64'hA5A5)) dut16 (
    .CLK(clk), .RST(rst), .LOAD(load), .REG_IN(din16),
`ifdef REG_SCH_PARITY_EN
    .PAR_ERR_INJ(inj16), .REG_PAR(par16),
`endif
    .REG_OUT(dout16)
  );

  // Rising edges at 200, 400, ... ns; CLK is high for the first 100 ns of each period.
  initial begin
    clk = 1'b1;
    forever #100 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs while CLK is high; an asserted reset is checked right away, before any edge.
  task automatic drive(input logic r, input logic l, input logic [7:0] d8, input logic [15:0] d16);
    rst   = r;
    load  = l;
    din8  = d8;
    din16 = d16;
    if (r) begin
      #1;
      chk("async_reset_8", 64'(dout8), 64'(RV8));
      chk("async_reset_16", 64'(dout16), 64'(RV16));
    end
  endtask

  // Apply one edge and advance the model by the specified rules.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m8   = RV8;
      m16  = RV16;
      mpar = ^RV8;
    end else if (load) begin
      m8   = din8;
      m16  = din16;
`ifdef REG_SCH_PARITY_EN
      mpar = (^din8) ^ inj;
`endif
    end
    #10;
  endtask

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vec [8];

  initial begin
    vec[0] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vec[1] = '{1'b0, 1'b1, 8'h01, 8'h01};
    vec[2] = '{1'b0, 1'b0, 8'h02, 8'h01};
    vec[3] = '{1'b0, 1'b0, 8'h03, 8'h01};
    vec[4] = '{1'b1, 1'b1, 8'h04, 8'h00};
    vec[5] = '{1'b0, 1'b1, 8'h05, 8'h05};
    vec[6] = '{1'b0, 1'b1, 8'h06, 8'h06};
    vec[7] = '{1'b0, 1'b1, 8'h07, 8'h07};

    rst   = 1'b1;
    load  = 1'b0;
    din8  = 8'h00;
    din16 = 16'h0000;
`ifdef REG_SCH_PARITY_EN
    inj   = 1'b0;
    inj16 = 1'b0;
`endif
    m8   = RV8;
    m16  = RV16;
    mpar = ^RV8;
    #1;
    chk("power_on_reset_8", 64'(dout8), 64'(RV8));
    chk("power_on_reset_16", 64'(dout16), 64'(RV16));
`ifdef REG_SCH_PARITY_EN
    chk("power_on_reset_par", 64'(par8), 64'(1'b0));
`endif
    #49;

    // Directed table: load, hold, reset ignoring LOAD, release and resume.
    for (int i = 0; i < 8; i++) begin
      drive(vec[i].rst, vec[i].load, vec[i].din, 16'h0000);
      tick();
      chk($sformatf("vec%0d", i), 64'(dout8), 64'(vec[i].exp));
      #20;
    end

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
`ifdef REG_SCH_PARITY_EN
      inj = 1'($urandom_range(0, 3) == 0);
`endif
      drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            8'($urandom), 16'($urandom));
      tick();
      chk("rand_8", 64'(dout8), 64'(m8));
      chk("rand_16", 64'(dout16), 64'(m16));
`ifdef REG_SCH_PARITY_EN
      chk("rand_par", 64'(par8), 64'(mpar));
`endif
      #20;
    end

`ifdef REG_SCH_PARITY_EN
    inj = 1'b0;
`endif
    // Full width with a non-zero reset value.
    drive(1'b1, 1'b1, 8'h00, 16'h1234);
    tick();
    chk("w16_reset", 64'(dout16), 64'h0000_0000_0000_A5A5);
    #20;
    drive(1'b0, 1'b1, 8'h00, 16'hFFFF);
    tick();
    chk("w16_load_ffff", 64'(dout16), 64'h0000_0000_0000_FFFF);
    #20;
    drive(1'b0, 1'b1, 8'h00, 16'h0000);
    tick();
    chk("w16_load_0000", 64'(dout16), 64'h0);
    #20;
    drive(1'b0, 1'b0, 8'h00, 16'h5A5A);
    tick();
    chk("w16_hold", 64'(dout16), 64'h0);
    #20;

`ifdef REG_SCH_PARITY_EN
    // Parity: odd word, even word, injected error, then reset.
    drive(1'b0, 1'b1, 8'h07, 16'h0000);
    tick();
    chk("par_07", 64'(par8), 64'(1'b1));
    #20;
    drive(1'b0, 1'b1, 8'h03, 16'h0000);
    tick();
    chk("par_03", 64'(par8), 64'(1'b0));
    #20;
    inj = 1'b1;
    drive(1'b0, 1'b1, 8'h03, 16'h0000);
    tick();
    chk("par_03_inj", 64'(par8), 64'(1'b1));
    #20;
    inj = 1'b0;
    drive(1'b1, 1'b0, 8'h03, 16'h0000);
    chk("par_async_reset", 64'(par8), 64'(1'b0));
    tick();
    chk("par_reset", 64'(par8), 64'(1'b0));
    #20;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
